// File: rtl/gauss3x3_rgb888_if.sv
// Window-in / BRAM-write-out bundle for the 3x3 Gaussian blur stage.
// slave: the filter (takes iEn/iValid/iWin0..8, drives oWe/oAddr/oPixel/oFrameDone/oBusy);
// master: the side that feeds windows and observes the frame-buffer writes.
interface gauss3x3_rgb888_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 17
);
   logic              iEn;
   logic              iValid;
   logic [DATA_W-1:0] iWin0;
   logic [DATA_W-1:0] iWin1;
   logic [DATA_W-1:0] iWin2;
   logic [DATA_W-1:0] iWin3;
   logic [DATA_W-1:0] iWin4;
   logic [DATA_W-1:0] iWin5;
   logic [DATA_W-1:0] iWin6;
   logic [DATA_W-1:0] iWin7;
   logic [DATA_W-1:0] iWin8;
   logic              oWe;
   logic [ADDR_W-1:0] oAddr;
   logic [DATA_W-1:0] oPixel;
   logic              oFrameDone;
   logic              oBusy;

   modport master (
      output iEn, iValid,
      output iWin0, iWin1, iWin2,
      output iWin3, iWin4, iWin5,
      output iWin6, iWin7, iWin8,
      input  oWe, oAddr, oPixel,
      input  oFrameDone, oBusy
   );

   modport slave (
      input  iEn, iValid,
      input  iWin0, iWin1, iWin2,
      input  iWin3, iWin4, iWin5,
      input  iWin6, iWin7, iWin8,
      output oWe, oAddr, oPixel,
      output oFrameDone, oBusy
   );
endinterface

// File: rtl/gauss3x3_rgb888.sv
// 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16) per RGB888 channel, 3-stage
// pipeline, writing raster-ordered pixels to a frame-buffer BRAM.
// Ports: iClk, iRst (sync, active-high), bus (slave modport):
//   iEn advance enable, iValid + iWin0..8 window in,
//   oWe/oAddr/oPixel BRAM write, oFrameDone last-pixel pulse, oBusy.
// Optional macro GAUSS_ROUND_EN: round half up ((s+8)>>4) instead of truncating.
module gauss3x3_rgb888 #(
   parameter int DATA_W = 24,
   parameter int WIDTH  = 480,
   parameter int HEIGHT = 272,
   parameter int ADDR_W = 17
) (
   input logic iClk,
   input logic iRst,
   gauss3x3_rgb888_if.slave bus
);

   localparam int NPIX = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t            state;
   logic              rV1, rV2, rV3;
   logic [9:0]        rT [3];
   logic [9:0]        rM [3];
   logic [9:0]        rB [3];
   logic [11:0]       rS [3];
   logic [DATA_W-1:0] rPix;
   logic [ADDR_W-1:0] rAddr;
   logic [DATA_W-1:0] win [9];
   logic              wr;
   logic              atLast;

   assign win[0] = bus.iWin0;
   assign win[1] = bus.iWin1;
   assign win[2] = bus.iWin2;
   assign win[3] = bus.iWin3;
   assign win[4] = bus.iWin4;
   assign win[5] = bus.iWin5;
   assign win[6] = bus.iWin6;
   assign win[7] = bus.iWin7;
   assign win[8] = bus.iWin8;

   function automatic logic [9:0] rowSum(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] c
   );
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   function automatic logic [11:0] colSum(
      input logic [9:0] t,
      input logic [9:0] m,
      input logic [9:0] b
   );
      return {2'b00, t} + {1'b0, m, 1'b0} + {2'b00, b};
   endfunction

   // 4080 + 8 still fits in 12 bits, so the rounded form cannot overflow.
   function automatic logic [7:0] scale(input logic [11:0] s);
      logic [11:0] r;
`ifdef GAUSS_ROUND_EN
      r = s + 12'd8;
`else
      r = s;
`endif
      return r[11:4];
   endfunction

   // Stall gating keeps a frozen S3 from writing the same pixel twice.
   assign wr     = rV3 & bus.iEn;
   assign atLast = (rAddr == LAST);

   assign bus.oWe        = wr;
   assign bus.oAddr      = rAddr;
   assign bus.oPixel     = rPix;
   assign bus.oFrameDone = wr & atLast & (state == ACTIVE);
   assign bus.oBusy      = (state == ACTIVE) | rV1 | rV2 | rV3;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
         rV1   <= 1'b0;
         rV2   <= 1'b0;
         rV3   <= 1'b0;
         rPix  <= '0;
         rAddr <= '0;
         for (int c = 0; c < 3; c++) begin
            rT[c] <= '0;
            rM[c] <= '0;
            rB[c] <= '0;
            rS[c] <= '0;
         end
      end else if (bus.iEn) begin
         rV1 <= bus.iValid;
         rV2 <= rV1;
         rV3 <= rV2;
         for (int c = 0; c < 3; c++) begin
            rT[c] <= rowSum(win[0][8*c +: 8],
                            win[1][8*c +: 8],
                            win[2][8*c +: 8]);
            rM[c] <= rowSum(win[3][8*c +: 8],
                            win[4][8*c +: 8],
                            win[5][8*c +: 8]);
            rB[c] <= rowSum(win[6][8*c +: 8],
                            win[7][8*c +: 8],
                            win[8][8*c +: 8]);
            rS[c] <= colSum(rT[c], rM[c], rB[c]);
            rPix[8*c +: 8] <= scale(rS[c]);
         end

         if (rV3) begin
            if (atLast) rAddr <= '0;
            else        rAddr <= rAddr + ADDR_W'(1);
         end

         // A window arriving with the last write keeps the next frame active.
         unique case (state)
            IDLE: begin
               if (bus.iValid) state <= ACTIVE;
            end
            ACTIVE: begin
               if (rV3 && atLast && !bus.iValid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gauss3x3_rgb888.sv
// Randomised + directed bench for gauss3x3_rgb888 on a 4x3 frame.
// Scoreboard queue fed by the stimulus, drained by a negedge monitor.
module tb_gauss3x3_rgb888;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int AW   = 4;
   localparam int DW   = 24;
   localparam int NPIX = W * H;

   typedef struct {
      logic [23:0] pix;
      int          addr;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   gauss3x3_rgb888_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   gauss3x3_rgb888 #(
      .DATA_W(DW),
      .WIDTH (W),
      .HEIGHT(H),
      .ADDR_W(AW)
   ) dut (
      .iClk(clk),
      .iRst(rst),
      .bus (bus)
   );

   exp_t        sbQ [$];
   exp_t        e;
   logic [23:0] wrHist [$];
   logic [23:0] win [9];
   int          nChk = 0;
   int          nFail = 0;
   int          enCnt = 0;
   int          nextAddr = 0;
   int          nWrites = 0;
   int          fdCnt = 0;
   int          lastAddr = 0;
   int          base;

   task automatic check(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] req
   );
      nChk++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Whole-kernel weighted sum per channel, then /16.
   function automatic logic [23:0] gaussRef(input logic [23:0] w [9]);
      int          wt [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      logic [23:0] res;
      int          s;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         s = 0;
         for (int k = 0; k < 9; k++)
            s += wt[k] * int'(w[k][8*ch +: 8]);
`ifdef GAUSS_ROUND_EN
         s = (s + 8) / 16;
`else
         s = s / 16;
`endif
         res[8*ch +: 8] = s[7:0];
      end
      return res;
   endfunction

   always @(posedge clk)
      if (bus.iEn && !rst) enCnt <= enCnt + 1;

   always @(negedge clk) begin
      if (!rst && bus.oWe === 1'b1) begin
         nWrites++;
         wrHist.push_back(bus.oPixel);
         lastAddr = int'(bus.oAddr);
         if (bus.oFrameDone === 1'b1) fdCnt++;
         if (sbQ.size() == 0) begin
            nChk++;
            nFail++;
            $display("FAIL unexpected_write: got addr %0d pixel %06h required none",
                     bus.oAddr, bus.oPixel);
         end else begin
            e = sbQ.pop_front();
            check("pixel", 32'(bus.oPixel), 32'(e.pix));
            check("addr", 32'(bus.oAddr), 32'(e.addr));
            check("latency", 32'(enCnt), 32'(e.cyc));
            check("frameDone", 32'(bus.oFrameDone),
                  32'(e.addr == NPIX - 1));
         end
      end
   end

   task automatic step(input logic v, input logic en, input logic r);
      bus.iValid = v;
      bus.iEn    = en;
      rst        = r;
      bus.iWin0  = win[0];
      bus.iWin1  = win[1];
      bus.iWin2  = win[2];
      bus.iWin3  = win[3];
      bus.iWin4  = win[4];
      bus.iWin5  = win[5];
      bus.iWin6  = win[6];
      bus.iWin7  = win[7];
      bus.iWin8  = win[8];
      if (r) begin
         sbQ.delete();
         nextAddr = 0;
      end else if (v && en) begin
         sbQ.push_back('{gaussRef(win), nextAddr, enCnt + 3});
         nextAddr = (nextAddr + 1) % NPIX;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic setAll(input logic [23:0] p);
      for (int k = 0; k < 9; k++) win[k] = p;
   endtask

   task automatic randWin();
      for (int k = 0; k < 9; k++) win[k] = 24'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sbQ.size() != 0; i++)
         step(1'b0, 1'b1, 1'b0);
      check("drain_timeout", 32'(sbQ.size()), 32'd0);
   endtask

   initial begin
      bus.iEn    = 1'b1;
      bus.iValid = 1'b0;
      setAll(24'h0);

      // Reset state
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("rst_we", 32'(bus.oWe), 32'd0);
      check("rst_addr", 32'(bus.oAddr), 32'd0);
      check("rst_pixel", 32'(bus.oPixel), 32'd0);
      check("rst_fd", 32'(bus.oFrameDone), 32'd0);
      check("rst_busy", 32'(bus.oBusy), 32'd0);

      // Uniform window
      base = nWrites;
      setAll(24'h808080);
      step(1'b1, 1'b1, 1'b0);
      setAll(24'h0);
      drain();
      check("uniform_n", 32'(nWrites - base), 32'd1);
      check("uniform_pix", 32'(wrHist[$]), 32'h808080);
      check("uniform_addr", 32'(lastAddr), 32'd0);

      // Impulse
      setAll(24'h0);
      win[4] = 24'hFF0000;
      step(1'b1, 1'b1, 1'b0);
      setAll(24'h0);
      drain();
`ifdef GAUSS_ROUND_EN
      check("impulse", 32'(wrHist[$]), 32'h400000);
`else
      check("impulse", 32'(wrHist[$]), 32'h3F0000);
`endif

      // Full scale then zero, consecutive
      setAll(24'hFFFFFF);
      step(1'b1, 1'b1, 1'b0);
      setAll(24'h000000);
      step(1'b1, 1'b1, 1'b0);
      drain();
      check("max_pix", 32'(wrHist[$-1]), 32'hFFFFFF);
      check("zero_pix", 32'(wrHist[$]), 32'h000000);

      // Stall between back-to-back valids
      step(1'b0, 1'b1, 1'b1);
      base = nWrites;
      randWin();
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         randWin();
         step(1'b1, 1'b0, 1'b0);
         check("stall_we", 32'(bus.oWe), 32'd0);
      end
      randWin();
      step(1'b1, 1'b1, 1'b0);
      randWin();
      step(1'b1, 1'b1, 1'b0);
      drain();
      check("stall_n", 32'(nWrites - base), 32'd3);
      check("stall_last_addr", 32'(lastAddr), 32'd2);

      // Frame wrap
      step(1'b0, 1'b1, 1'b1);
      base  = nWrites;
      fdCnt = 0;
      for (int i = 0; i < NPIX + 1; i++) begin
         randWin();
         step(1'b1, 1'b1, 1'b0);
      end
      drain();
      step(1'b0, 1'b1, 1'b0);
      check("wrap_n", 32'(nWrites - base), 32'(NPIX + 1));
      check("wrap_fd_count", 32'(fdCnt), 32'd1);
      check("wrap_last_addr", 32'(lastAddr), 32'd0);
      check("wrap_busy", 32'(bus.oBusy), 32'd0);

      // Reset mid-frame with a window in flight
      step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         randWin();
         step(1'b1, 1'b1, 1'b0);
      end
      drain();
      base = nWrites;
      randWin();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
      check("rst_flush_n", 32'(nWrites - base), 32'd0);
      randWin();
      step(1'b1, 1'b1, 1'b0);
      drain();
      check("rst_restart_addr", 32'(lastAddr), 32'd0);

      // Random traffic with random stalls and bubbles
      fdCnt = 0;
      base  = nWrites;
      for (int i = 0; i < 300; i++) begin
         randWin();
         step(1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 9) < 8),
              1'b0);
      end
      drain();
      check("rand_fd_count", 32'(fdCnt),
            32'((1 + nWrites - base) / NPIX));

      check("sb_empty", 32'(sbQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nChk, nFail);
      $finish;
   end

endmodule
